seq_datapath: RTL and testbench

SEQ_DATAPATH -- requirements
Module: seq_datapath

---
 rtl/seq_datapath_pkg.sv | 40 ++++
 rtl/seq_datapath_alu.sv | 67 ++++++
 rtl/seq_datapath.sv | 120 ++++++++++++
 tb/tb_seq_datapath.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_datapath_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the sequential datapath.
package seq_datapath_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_ADDC = 4'd2,
        OP_SUB  = 4'd3,
        OP_CMP  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_MOV  = 4'd8,
        OP_MOVI = 4'd9,
        OP_LSHI = 4'd10
    } opcode_e;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_L = 1;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 4;
    localparam int unsigned NFLAGS = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // Undefined codes fall into the default branch and therefore never write.
    function automatic logic op_writes(input logic [3:0] op);
        case (op)
            OP_ADD, OP_ADDC, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_MOV, OP_MOVI, OP_LSHI: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_datapath_alu.sv
// Combinational ALU: computes the result and the complete next flag vector,
// passing through any flag the opcode leaves untouched.
module seq_alu
    import seq_datapath_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [7:0]        imm,
    input  logic              carry_in,
    input  logic [NFLAGS-1:0] flags_in,
    output logic [WIDTH-1:0]  result,
    output logic [NFLAGS-1:0] flags_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [4:0]     shamt;
    logic [4:0]     rmag;

    assign sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADDC) && carry_in};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign shamt = imm[4:0];
    // Magnitude of a negative 5-bit shift; -16 wraps to 5'b10000 which is still 16.
    assign rmag  = 5'(~shamt + 5'd1);

    always_comb begin
        result    = '0;
        flags_out = flags_in;
        case (op)
            OP_ADD, OP_ADDC: begin
                result            = sum[WIDTH-1:0];
                flags_out[FLAG_C] = sum[WIDTH];
                flags_out[FLAG_F] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                flags_out[FLAG_Z] = (sum[WIDTH-1:0] == '0);
            end
            OP_SUB: begin
                result            = diff[WIDTH-1:0];
                flags_out[FLAG_C] = diff[WIDTH];
                flags_out[FLAG_F] = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                flags_out[FLAG_Z] = (diff[WIDTH-1:0] == '0);
            end
            OP_CMP: begin
                result            = diff[WIDTH-1:0];
                flags_out[FLAG_L] = diff[WIDTH];
                flags_out[FLAG_N] = $signed(a) < $signed(b);
                flags_out[FLAG_Z] = (a == b);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_MOV:  result = b;
            OP_MOVI: result = WIDTH'(imm);
            OP_LSHI: begin
                if (!shamt[4]) begin
                    if (32'(shamt) < WIDTH) result = a << shamt;
                end else begin
                    if (32'(rmag) < WIDTH) result = a >> rmag;
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/seq_datapath.sv
// Three-state (IDLE/EXEC/WB) single-issue datapath with register file,
// registered ALU stage and flag register.
module seq_datapath
    import seq_datapath_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 16,
    parameter int RSEL  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [RSEL-1:0]   in_rdst,
    input  logic [RSEL-1:0]   in_rsrc,
    input  logic [7:0]        in_imm,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic [NFLAGS-1:0] flags,
    input  logic [RSEL-1:0]   dbg_sel,
    output logic [WIDTH-1:0]  dbg_data
);

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [RSEL-1:0]   rdst_q, rdst_d;
    logic [RSEL-1:0]   rsrc_q, rsrc_d;
    logic [7:0]        imm_q, imm_d;
    logic [WIDTH-1:0]  alu_res_q, alu_res_d;
    logic [NFLAGS-1:0] alu_flags_q, alu_flags_d;
    logic [NFLAGS-1:0] flags_q, flags_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [WIDTH-1:0]  rf_q [NREGS];
    logic [WIDTH-1:0]  rf_d [NREGS];

    logic [WIDTH-1:0]  alu_out;
    logic [NFLAGS-1:0] alu_flags;

    seq_alu #(.WIDTH(WIDTH)) u_alu (
        .op        (op_q),
        .a         (rf_q[rdst_q]),
        .b         (rf_q[rsrc_q]),
        .imm       (imm_q),
        .carry_in  (flags_q[FLAG_C]),
        .flags_in  (flags_q),
        .result    (alu_out),
        .flags_out (alu_flags)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rdst_d      = rdst_q;
        rsrc_d      = rsrc_q;
        imm_d       = imm_q;
        alu_res_d   = alu_res_q;
        alu_flags_d = alu_flags_q;
        flags_d     = flags_q;
        result_d    = result_q;
        rf_d        = rf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    rdst_d  = in_rdst;
                    rsrc_d  = in_rsrc;
                    imm_d   = in_imm;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_res_d   = alu_out;
                alu_flags_d = alu_flags;
                state_d     = ST_WB;
            end
            ST_WB: begin
                // Unaffected flag bits were already passed through by the ALU.
                flags_d  = alu_flags_q;
                result_d = alu_res_q;
                if (op_writes(op_q)) rf_d[rdst_q] = alu_res_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            rdst_q      <= '0;
            rsrc_q      <= '0;
            imm_q       <= '0;
            alu_res_q   <= '0;
            alu_flags_q <= '0;
            flags_q     <= '0;
            result_q    <= '0;
            rf_q        <= '{default: '0};
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rdst_q      <= rdst_d;
            rsrc_q      <= rsrc_d;
            imm_q       <= imm_d;
            alu_res_q   <= alu_res_d;
            alu_flags_q <= alu_flags_d;
            flags_q     <= flags_d;
            result_q    <= result_d;
            rf_q        <= rf_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign done     = (state_q == ST_WB);
    assign result   = result_q;
    assign flags    = flags_q;
    assign dbg_data = rf_q[dbg_sel];

endmodule

// File: tb/tb_seq_datapath.sv
// Directed bench driving a 16-bit/16-register and an 8-bit/4-register instance.
module tb_seq_datapath;
    import seq_datapath_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vld = 1'b0;
    logic       sel8 = 1'b0;
    logic [3:0] op = '0;
    logic [3:0] rdst = '0;
    logic [3:0] rsrc = '0;
    logic [3:0] dsel = '0;
    logic [7:0] imm = '0;

    logic        rdy16, done16, rdy8, done8;
    logic [15:0] res16, dbg16;
    logic [7:0]  res8, dbg8;
    logic [4:0]  fl16, fl8;

    logic [31:0] rdy_s, done_s, res_s, fl_s, dbg_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_datapath #(.WIDTH(16), .NREGS(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(vld & ~sel8), .in_ready(rdy16),
        .in_op(op), .in_rdst(rdst), .in_rsrc(rsrc), .in_imm(imm),
        .done(done16), .result(res16), .flags(fl16),
        .dbg_sel(dsel), .dbg_data(dbg16)
    );

    seq_datapath #(.WIDTH(8), .NREGS(4)) dut8 (
        .clk(clk), .reset(reset), .in_valid(vld & sel8), .in_ready(rdy8),
        .in_op(op), .in_rdst(rdst[1:0]), .in_rsrc(rsrc[1:0]), .in_imm(imm),
        .done(done8), .result(res8), .flags(fl8),
        .dbg_sel(dsel[1:0]), .dbg_data(dbg8)
    );

    always_comb begin
        rdy_s  = sel8 ? 32'(rdy8)  : 32'(rdy16);
        done_s = sel8 ? 32'(done8) : 32'(done16);
        res_s  = sel8 ? 32'(res8)  : 32'(res16);
        fl_s   = sel8 ? 32'(fl8)   : 32'(fl16);
        dbg_s  = sel8 ? 32'(dbg8)  : 32'(dbg16);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] idx, input logic [31:0] exp);
        dsel = idx;
        #1;
        check(tag, dbg_s, exp);
    endtask

    // Offer one instruction in IDLE and follow it through EXEC and WB.
    task automatic issue(input logic [3:0] o, input logic [3:0] d, input logic [3:0] s,
                         input logic [7:0] i);
        @(negedge clk);
        op = o; rdst = d; rsrc = s; imm = i; vld = 1'b1;
        check("ready_idle", rdy_s, 1);
        @(negedge clk);
        vld = 1'b0;
        check("done_exec", done_s, 0);
        @(negedge clk);
        check("done_wb", done_s, 1);
        @(negedge clk);
        check("done_after", done_s, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_ready", rdy_s, 1);
        check("rst_done", done_s, 0);
        check("rst_flags", fl_s, 0);
        check("rst_result", res_s, 0);
        chk_reg("rst_r1", 4'd1, 0);
    endtask

    initial begin
        // ---------------- 16-bit instance ----------------
        sel8 = 1'b0;
        do_reset();

        issue(OP_MOVI, 4'd1, 4'd0, 8'hFF);
        issue(OP_MOVI, 4'd2, 4'd0, 8'h01);
        issue(OP_ADD,  4'd1, 4'd2, 8'h00);
        chk_reg("add_r1", 4'd1, 'h0100);
        check("add_flags", fl_s, 'h00);
        check("add_result", res_s, 'h0100);

        issue(OP_MOVI, 4'd3, 4'd0, 8'hFF);
        issue(OP_LSHI, 4'd3, 4'd0, 8'd8);
        chk_reg("lshi_r3", 4'd3, 'hFF00);
        issue(OP_MOVI, 4'd8, 4'd0, 8'hFF);
        issue(OP_OR,   4'd3, 4'd8, 8'h00);
        chk_reg("or_r3", 4'd3, 'hFFFF);
        issue(OP_ADD,  4'd3, 4'd2, 8'h00);
        chk_reg("wrap_r3", 4'd3, 'h0000);
        check("wrap_flags", fl_s, 'h09);
        issue(OP_ADDC, 4'd4, 4'd0, 8'h00);
        chk_reg("addc_r4", 4'd4, 'h0001);
        check("addc_flags", fl_s, 'h00);

        issue(OP_MOVI, 4'd5, 4'd0, 8'h7F);
        issue(OP_LSHI, 4'd5, 4'd0, 8'd8);
        issue(OP_MOVI, 4'd9, 4'd0, 8'hFF);
        issue(OP_OR,   4'd5, 4'd9, 8'h00);
        issue(OP_MOVI, 4'd6, 4'd0, 8'h01);
        issue(OP_ADD,  4'd5, 4'd6, 8'h00);
        chk_reg("ovf_r5", 4'd5, 'h8000);
        check("ovf_flags", fl_s, 'h04);
        issue(OP_CMP,  4'd6, 4'd5, 8'h00);
        chk_reg("cmp_r6", 4'd6, 'h0001);
        check("cmp_flags", fl_s, 'h06);
        check("cmp_result", res_s, 'h8001);

        issue(OP_LSHI, 4'd5, 4'd0, 8'h1C);
        chk_reg("lshr4_r5", 4'd5, 'h0800);
        issue(OP_LSHI, 4'd5, 4'd0, 8'h10);
        chk_reg("lshr16_r5", 4'd5, 'h0000);
        issue(OP_SUB,  4'd2, 4'd4, 8'h00);
        chk_reg("sub_r2", 4'd2, 'h0000);
        check("sub_flags", fl_s, 'h0A);
        issue(4'hF,    4'd6, 4'd1, 8'h33);
        chk_reg("undef_r6", 4'd6, 'h0001);
        check("undef_flags", fl_s, 'h0A);
        issue(OP_ADD,  4'd6, 4'd6, 8'h00);
        chk_reg("self_r6", 4'd6, 'h0002);
        check("self_flags", fl_s, 'h02);
        issue(OP_MOV,  4'd9, 4'd1, 8'h00);
        chk_reg("mov_r9", 4'd9, 'h0100);

        // in_valid held high for six cycles with changing fields
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vld = 1'b1; op = OP_MOVI; rdst = 4'(10 + i); imm = 8'(17 * (i + 1));
            check("hold_ready", rdy_s, (i == 0 || i == 3) ? 1 : 0);
            check("hold_done",  done_s, (i == 2 || i == 5) ? 1 : 0);
        end
        @(negedge clk);
        vld = 1'b0;
        chk_reg("hold_r10", 4'd10, 'h11);
        chk_reg("hold_r11", 4'd11, 'h00);
        chk_reg("hold_r12", 4'd12, 'h00);
        chk_reg("hold_r13", 4'd13, 'h44);

        // reset during EXEC aborts the instruction
        @(negedge clk);
        op = OP_MOVI; rdst = 4'd7; imm = 8'h55; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0; reset = 1'b1;
        check("abort_exec_done", done_s, 0);
        @(negedge clk);
        check("abort_done", done_s, 0);
        reset = 1'b0;
        #1;
        check("abort_ready", rdy_s, 1);
        @(negedge clk);
        check("abort_done2", done_s, 0);
        chk_reg("abort_r7", 4'd7, 0);
        check("abort_flags", fl_s, 0);
        chk_reg("abort_r1", 4'd1, 0);

        // reset wins over a simultaneous handshake
        @(negedge clk);
        reset = 1'b1; vld = 1'b1; op = OP_MOVI; rdst = 4'd1; imm = 8'h33;
        @(negedge clk);
        reset = 1'b0; vld = 1'b0;
        #1;
        check("prio_ready", rdy_s, 1);
        @(negedge clk);
        check("prio_done", done_s, 0);
        @(negedge clk);
        check("prio_done2", done_s, 0);
        chk_reg("prio_r1", 4'd1, 0);

        // ---------------- 8-bit instance ----------------
        sel8 = 1'b1;
        do_reset();
        issue(OP_MOVI, 4'd1, 4'd0, 8'hFF);
        issue(OP_MOVI, 4'd2, 4'd0, 8'h01);
        issue(OP_ADD,  4'd1, 4'd2, 8'h00);
        chk_reg("w8_add_r1", 4'd1, 'h00);
        check("w8_add_flags", fl_s, 'h09);
        issue(OP_MOVI, 4'd3, 4'd0, 8'h7F);
        issue(OP_ADD,  4'd3, 4'd2, 8'h00);
        chk_reg("w8_ovf_r3", 4'd3, 'h80);
        check("w8_ovf_flags", fl_s, 'h04);
        issue(OP_CMP,  4'd2, 4'd3, 8'h00);
        chk_reg("w8_cmp_r2", 4'd2, 'h01);
        check("w8_cmp_flags", fl_s, 'h06);
        check("w8_cmp_result", res_s, 'h81);
        issue(OP_LSHI, 4'd2, 4'd0, 8'd7);
        chk_reg("w8_lsh7_r2", 4'd2, 'h80);
        issue(OP_LSHI, 4'd2, 4'd0, 8'd8);
        chk_reg("w8_lsh8_r2", 4'd2, 'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
